// File: rtl/seven_seg_scanner_if.sv
// Display-side bundle for seven_seg_scanner: digit/dp inputs from the
// counter chain, scan enable, and the multiplexed pin outputs.
// The master drives digits/enable; the slave (the scanner) drives the pins.
interface seven_seg_scanner_if #(
  parameter int NUM_DIGITS = 4
);
  logic                      enable;
  logic [4*NUM_DIGITS-1:0]   digits_in;
  logic [NUM_DIGITS-1:0]     dp_in;
  logic [NUM_DIGITS-1:0]     anode_n;
  logic [6:0]                seg_n;
  logic                      dp_n;
  logic                      frame_tick;

  modport master (
    output enable, digits_in, dp_in,
    input  anode_n, seg_n, dp_n, frame_tick
  );

  modport slave (
    input  enable, digits_in, dp_in,
    output anode_n, seg_n, dp_n, frame_tick
  );
endinterface

// File: rtl/seven_seg_scanner.sv
// Time-multiplexed 7-segment driver. Digits are captured into a shadow
// register once per frame (tear-free) and scanned one slot at a time onto
// shared active-low segment lines, with a blanking guard at the start of
// each slot to suppress ghosting.
// Optional feature macro: SEVEN_SEG_LEADING_ZERO_BLANK_EN (leading-zero
// blanking; when undefined every digit is always shown).
module seven_seg_scanner #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 100000,
  parameter int GUARD_CYCLES = 16
) (
  input  logic               clk,
  input  logic               rst,
  seven_seg_scanner_if.slave bus
);

  localparam int PRE_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
  // All-zero shadow blanks every digit except digit 0.
  localparam logic [NUM_DIGITS-1:0] BLANK_RST = ~(NUM_DIGITS'(1));
`else
  localparam logic [NUM_DIGITS-1:0] BLANK_RST = '0;
`endif

  // Active-low segment pattern {g,f,e,d,c,b,a}; 10..15 render as a dash.
  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return 7'b0111111;
    endcase
  endfunction

  logic [PRE_W-1:0]      pre;
  logic [IDX_W-1:0]      idx;
  logic [3:0]            shadow_dig [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] shadow_dp;
  logic [NUM_DIGITS-1:0] blank;
  logic [NUM_DIGITS-1:0] blank_next;
  logic                  wrap_q;

  logic                  pre_tc;
  logic                  frame_start;
  logic                  in_guard;

  logic [NUM_DIGITS-1:0] anode_next;
  logic [6:0]            seg_next;
  logic                  dp_next;

  assign pre_tc      = (pre == PRE_LAST);
  assign frame_start = bus.enable && pre_tc && (idx == IDX_LAST);
  // Signed compare keeps GUARD_CYCLES = 0 well-defined (never in guard).
  assign in_guard    = (int'(pre) < GUARD_CYCLES);

  // Prescaler and slot index; both freeze while enable is low.
  // NOTE: clocked blocks use non-blocking (<=) so every register samples
  // pre-edge values; combinational blocks use blocking (=).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre <= '0;
      idx <= '0;
    end else if (bus.enable) begin
      if (pre_tc) begin
        pre <= '0;
        idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end else begin
        pre <= pre + 1'b1;
      end
    end
  end

  // Leading-zero blank flags derived from the values being captured, so
  // they land together with the shadow and stay fixed for the frame.
  always_comb begin
    blank_next = '0;
`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
    begin : lz_scan
      logic leading;
      leading = 1'b1;
      for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
        if (leading && (bus.digits_in[4*i +: 4] == 4'd0) && !bus.dp_in[i]) begin
          blank_next[i] = 1'b1;
        end else begin
          leading = 1'b0;
        end
      end
    end
`endif
  end

  // Shadow capture at frame start: the display never reads inputs directly.
  // NOTE: the shadow array is reset on purpose; the first frame after reset
  // must show defined zeros rather than power-up garbage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_DIGITS; i++) shadow_dig[i] <= 4'd0;
      shadow_dp <= '0;
      blank     <= BLANK_RST;
    end else if (frame_start) begin
      for (int i = 0; i < NUM_DIGITS; i++) shadow_dig[i] <= bus.digits_in[4*i +: 4];
      shadow_dp <= bus.dp_in;
      blank     <= blank_next;
    end
  end

  // Next pin values from the current slot state: dark unless enabled,
  // past the guard interval, and the selected digit is not blanked.
  // NOTE: every output gets a default first so no path infers a latch.
  always_comb begin
    anode_next = '1;
    seg_next   = 7'h7F;
    dp_next    = 1'b1;
    if (bus.enable && !in_guard && !blank[idx]) begin
      anode_next = ~(NUM_DIGITS'(1) << idx);
      seg_next   = decode(shadow_dig[idx]);
      dp_next    = ~shadow_dp[idx];
    end
  end

  // Registered pins; frame_tick trails the wrap by one enabled cycle so it
  // coincides with the first guard cycle of slot 0 on the pins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.anode_n    <= '1;
      bus.seg_n      <= 7'h7F;
      bus.dp_n       <= 1'b1;
      bus.frame_tick <= 1'b0;
      wrap_q         <= 1'b0;
    end else begin
      bus.anode_n <= anode_next;
      bus.seg_n   <= seg_next;
      bus.dp_n    <= dp_next;
      if (bus.enable) begin
        wrap_q         <= frame_start;
        bus.frame_tick <= wrap_q;
      end else begin
        bus.frame_tick <= 1'b0;
      end
    end
  end

endmodule
